stalin_sort_serializer: RTL and testbench
=========================================

Name: stalin_sort_serializer

Overview:
- Downstream stage of the stalin sort core. Captures the packed result vector and kept-element count when the sorter's level-high done asserts.
- Replays the kept elements one per beat on a valid/ready stream with a last marker.
- Sits between the sorter and any streaming consumer (UART TX, FIFO, bus bridge). The sorter holds done high until its next start, so this block is edge-triggered on it.

Parameters:
- N, 16, number of element slots in the packed input vector (same value as the sorter).
- WIDTH, 8, bit width per element.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_done  in  1  sorter done level; a capture happens on its rising edge.
- in_data  in  N*WIDTH  packed elements, element 0 at LSB, valid slots 0..in_len-1.
- in_len  in  CLOG2(N+1)  kept-element count.
- m_valid  out  1  output beat valid.
- m_data  out  WIDTH  current element.
- m_last  out  1  high on the final beat of a frame.
- m_ready  in  1  consumer ready.
- busy  out  1  frame being streamed.
- frame_done  out  1  one-cycle pulse when a frame finishes (including empty frames).
- overrun  out  1  sticky; set when a capture edge arrives while busy.

Behaviour:
- Reset values (rst=1 at a clock edge): state IDLE; m_valid, m_last, busy, frame_done, overrun all 0; m_data 0; internal index, length and done_q registers 0; captured buffer 0.
- Reset mid-stream aborts the frame immediately. No frame_done is issued for the aborted frame.
- Edge detect: cap = in_done & ~done_q, with done_q <= in_done every cycle. If in_done is high on the first cycle after reset, that counts as an edge.
- States: IDLE, STREAM.
- IDLE, cap=1, in_len>0:
  - Latch in_data into buf and latch len = min(in_len, N). in_len>N is clamped to N.
  - Set idx=0 and go to STREAM.
  - m_valid=1 on the next cycle, so latency is edge cycle +1.
- IDLE, cap=1, in_len=0: stay in IDLE, pulse frame_done on the next cycle, no beats.
- STREAM outputs:
  - m_valid=1, busy=1.
  - m_data = buf[idx*WIDTH +: WIDTH].
  - m_last = (idx == len-1).
  - m_data and m_last are stable while m_valid & ~m_ready.
  - Stalls of any length are allowed.
- STREAM transfer (m_valid & m_ready): if not last, idx <= idx+1.
- STREAM last transfer:
  - Go to IDLE and pulse frame_done on the next cycle.
  - m_valid drops on the next cycle; there are no back-to-back frames without an IDLE cycle.
- Throughput: one element per cycle while m_ready=1. A frame of L elements occupies exactly L STREAM cycles plus one IDLE cycle.
- cap while in STREAM, including the last-transfer cycle:
  - The new frame is dropped and overrun <= 1.
  - The current frame continues unaffected.
  - overrun clears only on rst.
- in_data and in_len are sampled only on the cap cycle. Later changes are ignored.
- Widths: idx and len are CLOG2(N+1) bits. Compare and increment are unsigned, with no wrap (idx never exceeds N-1).

Decomposition:
- Shared include stalin_sort_defs.vh holds:
  - the CLOG2 function, so the sorter and serializer share one definition;
  - the state encodings for this block (SER_IDLE=1'b0, SER_STREAM=1'b1).
- No sub-module needed beyond an inline rising-edge detector. Optionally factor it as edge_rise (1-bit register plus AND), reusable by other sorter-adjacent blocks.

Test Plan (N=4, WIDTH=8):
- Basic frame: in_data=0x_00_09_07_03, in_len=3, done rises, m_ready=1 → beats 0x03, 0x07, 0x09 on consecutive cycles starting edge+1. m_last only on 0x09. frame_done on the cycle after 0x09 transfers.
- Backpressure: same frame, m_ready toggles 1,0,0,1,0,1 → exactly 3 transfers, in order. m_data and m_last are held during every stall cycle.
- Empty frame: in_len=0, done rises → m_valid never asserts. frame_done pulses once at edge+1. busy stays 0.
- Level hold and overrun:
  - done held high 10 cycles → only one frame is emitted.
  - Then drop done, and raise it again while streaming a 4-element frame with m_ready=0 → the 4 original beats complete and overrun=1 sticks.
  - The second frame is never emitted.
- Clamp and full: in_len=5 (>N), in_data=0x04_03_02_01 → 4 beats 0x01..0x04, m_last on 0x04.
- Reset mid-stream: assert rst after the 2nd of 4 beats → next cycle all outputs are 0 and no frame_done. A fresh done edge then streams a full new frame correctly.

Source files
------------

// File: rtl/stalin_sort_serializer_pkg.sv
// Shared definitions for the stalin sort serializer: width helper and stream FSM states.
package stalin_sort_serializer_pkg;

  // Ceiling log2, usable in constant expressions for port and register widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

  typedef enum logic {
    SerIdle   = 1'b0,
    SerStream = 1'b1
  } ser_state_e;

endpackage

// File: rtl/stalin_sort_serializer_if.sv
// Valid/ready output stream of the serializer, one element per beat with a last marker.
interface stalin_sort_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/stalin_sort_serializer_edge_rise.sv
// Rising-edge detector: one-cycle pulse when d goes high; a high d right after reset counts.
module stalin_sort_serializer_edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/stalin_sort_serializer.sv
// Captures a sorter result on the rising edge of its done level and replays the kept
// elements one per beat on a valid/ready stream.
module stalin_sort_serializer
  import stalin_sort_serializer_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned LenW = clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_done,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [LenW-1:0]        in_len,
  stalin_sort_serializer_if.master m,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);
  localparam int unsigned IdxW = (N > 1) ? clog2(N) : 1;
  localparam logic [LenW-1:0] LenMax = LenW'(N);

  ser_state_e                  state_q, state_d;
  logic [N-1:0][WIDTH-1:0]     data_buf_q, data_buf_d;
  logic [LenW-1:0]             idx_q, idx_d;
  logic [LenW-1:0]             len_q, len_d;
  logic                        overrun_q, overrun_d;
  logic                        frame_done_q, frame_done_d;
  logic                        cap;
  logic                        is_last;

  stalin_sort_serializer_edge_rise u_edge_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (in_done),
    .rise (cap)
  );

  // len_q is at least 1 whenever this matters (STREAM), so len_q - 1 cannot wrap.
  assign is_last = (idx_q == len_q - LenW'(1));

  always_comb begin
    state_d      = state_q;
    data_buf_d   = data_buf_q;
    idx_d        = idx_q;
    len_d        = len_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    case (state_q)
      SerIdle: begin
        if (cap) begin
          if (in_len == '0) begin
            frame_done_d = 1'b1;
          end else begin
            data_buf_d = in_data;
            len_d      = (in_len > LenMax) ? LenMax : in_len;
            idx_d      = '0;
            state_d    = SerStream;
          end
        end
      end
      SerStream: begin
        // A new result while streaming is dropped; the current frame is untouched.
        if (cap) begin
          overrun_d = 1'b1;
        end
        if (m.ready) begin
          if (is_last) begin
            state_d      = SerIdle;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + LenW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SerIdle;
      data_buf_q   <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_buf_q   <= data_buf_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m.valid    = (state_q == SerStream);
  assign m.last     = m.valid & is_last;
  assign m.data     = m.valid ? data_buf_q[idx_q[IdxW-1:0]] : '0;
  assign busy       = (state_q == SerStream);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_stalin_sort_serializer.sv
// Directed plus randomized bench for stalin_sort_serializer (N=4, WIDTH=8) against a
// queue-based model of the frames the consumer should see.
module tb_stalin_sort_serializer;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int LenW  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_done;
  logic [N*WIDTH-1:0] in_data;
  logic [LenW-1:0]    in_len;
  logic               busy;
  logic               frame_done;
  logic               overrun;

  stalin_sort_serializer_if #(.WIDTH(WIDTH)) m_if ();

  stalin_sort_serializer #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_done    (in_done),
    .in_data    (in_data),
    .in_len     (in_len),
    .m          (m_if),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Model: elements still owed to the consumer, pending frame_done, sticky overrun.
  logic [WIDTH-1:0] exp_q[$];
  bit               prev_done;
  bit               fd_pend;
  bit               ovr_model;
  int               checks;
  int               errors;
  int               fd_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    prev_done = 1'b0;
    fd_pend   = 1'b0;
    ovr_model = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, ".m_valid"},    32'(m_if.valid), 32'd0);
    check({tag, ".m_last"},     32'(m_if.last),  32'd0);
    check({tag, ".m_data"},     32'(m_if.data),  32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".frame_done"}, 32'(frame_done), 32'd0);
    check({tag, ".overrun"},    32'(overrun),    32'd0);
  endtask

  // Compare current outputs to the model, advance the model across the next edge, step.
  task automatic tick();
    bit cap;
    bit fd_next;
    int n;
    check("m_valid", 32'(m_if.valid), 32'(exp_q.size() > 0));
    check("busy",    32'(busy),       32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("m_data", 32'(m_if.data), 32'(exp_q[0]));
      check("m_last", 32'(m_if.last), 32'(exp_q.size() == 1));
    end else begin
      check("m_last_idle", 32'(m_if.last), 32'd0);
    end
    check("frame_done", 32'(frame_done), 32'(fd_pend));
    check("overrun",    32'(overrun),    32'(ovr_model));
    if (frame_done === 1'b1) fd_seen++;
    if (rst) begin
      model_reset();
    end else begin
      fd_next = 1'b0;
      cap     = in_done && !prev_done;
      if (exp_q.size() > 0) begin
        if (cap) ovr_model = 1'b1;
        if (m_if.ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) fd_next = 1'b1;
        end
      end else if (cap) begin
        n = (int'(in_len) > N) ? N : int'(in_len);
        if (n == 0) fd_next = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(in_data[WIDTH*i +: WIDTH]);
      end
      prev_done = in_done;
      fd_pend   = fd_next;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pat[8];
    int fd_before;
    checks      = 0;
    errors      = 0;
    fd_seen     = 0;
    rst         = 1'b1;
    in_done     = 1'b0;
    in_data     = '0;
    in_len      = '0;
    m_if.ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_check("reset");
    rst = 1'b0;
    tick();

    // Basic frame with done held high: a single frame only.
    fd_before  = fd_seen;
    in_data    = 32'h0009_0703;
    in_len     = 3'd3;
    in_done    = 1'b1;
    m_if.ready = 1'b1;
    repeat (10) tick();
    in_done = 1'b0;
    repeat (2) tick();
    check("level_hold_frames", 32'(fd_seen - fd_before), 32'd1);

    // Backpressure: ready 1,0,0,1,0,1 after the capture edge.
    pat     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    in_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_if.ready = pat[i];
      tick();
    end
    in_done = 1'b0;
    repeat (2) tick();

    // Empty frame.
    fd_before = fd_seen;
    in_len    = 3'd0;
    in_done   = 1'b1;
    repeat (3) tick();
    in_done = 1'b0;
    tick();
    check("empty_frame_done", 32'(fd_seen - fd_before), 32'd1);

    // Overrun: second edge arrives while a stalled 4-element frame is streaming.
    in_data    = 32'h4433_2211;
    in_len     = 3'd4;
    m_if.ready = 1'b0;
    in_done    = 1'b1;
    tick();
    in_done = 1'b0;
    tick();
    in_data = 32'h8877_6655;
    in_done = 1'b1;
    repeat (2) tick();
    m_if.ready = 1'b1;
    repeat (6) tick();
    in_done = 1'b0;
    repeat (2) tick();
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Length clamp: in_len=5 > N.
    in_data = 32'h0403_0201;
    in_len  = 3'd5;
    in_done = 1'b1;
    repeat (6) tick();
    in_done = 1'b0;
    tick();

    // Reset after the second of four beats.
    fd_before = fd_seen;
    in_data   = 32'h1a2b_3c4d;
    in_len    = 3'd4;
    in_done   = 1'b1;
    tick();
    in_done = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    reset_check("mid_reset");
    rst = 1'b0;
    repeat (2) tick();
    check("mid_reset_no_done", 32'(fd_seen - fd_before), 32'd0);
    in_data = 32'hddcc_bbaa;
    in_done = 1'b1;
    repeat (6) tick();
    in_done = 1'b0;
    tick();

    // Randomized frames, ready and stray done pulses.
    for (int f = 0; f < 25; f++) begin
      in_data    = $urandom;
      in_len     = 3'($urandom_range(0, 5));
      in_done    = 1'b1;
      m_if.ready = 1'($urandom_range(0, 1));
      tick();
      in_done = 1'b0;
      for (int c = 0; c < 60 && (exp_q.size() > 0 || fd_pend); c++) begin
        m_if.ready = 1'($urandom_range(0, 1));
        in_done    = ($urandom_range(0, 9) == 0);
        tick();
      end
      in_done = 1'b0;
      tick();
    end
    m_if.ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() > 0 || fd_pend); c++) tick();
    check("drained_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
